midi_note_encoder: RTL and testbench

- Transmit-side counterpart of the synthesizer's MIDI decode path.
- Accepts single note-on and note-off requests from internal logic (sequencer or keyboard scan) and encodes them as MIDI channel-voice messages.
- Serialises the bytes on a 31250-baud UART line (8N1, LSB first) for the MIDI OUT/THRU jack.
- Supports optional running status to shorten repeated messages.

---
 rtl/midi_note_encoder_if.sv | 22 ++
 rtl/midi_note_encoder.sv | 155 +++++++++++++++
 tb/tb_midi_note_encoder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_note_encoder_if.sv
// Request/serial-output bundle between a note source and the MIDI note encoder.
interface midi_note_encoder_if;
  logic       iNoteOn;
  logic       iNoteOff;
  logic [6:0] iNoteNumber;
  logic [6:0] iVelocity;
  logic [3:0] iMidiCh;
  logic       oReady;
  logic       oMidiTx;
  logic [7:0] oTxByte;
  logic       oTxByteStb;

  modport master (
    output iNoteOn, iNoteOff, iNoteNumber, iVelocity, iMidiCh,
    input  oReady, oMidiTx, oTxByte, oTxByteStb
  );

  modport slave (
    input  iNoteOn, iNoteOff, iNoteNumber, iVelocity, iMidiCh,
    output oReady, oMidiTx, oTxByte, oTxByteStb
  );
endinterface

// File: rtl/midi_note_encoder.sv
// Encodes note-on/off requests as MIDI channel-voice messages and shifts them
// out as back-to-back 8N1 UART frames, optionally using running status.
module midi_note_encoder #(
  parameter int unsigned pClkHz   = 48000000,
  parameter int unsigned pBaud    = 31250,
  parameter int unsigned pRunStat = 1
) (
  input  logic                  iCLK,
  input  logic                  inRST,
  midi_note_encoder_if.slave    if_midi
);

  localparam int unsigned DIV   = pClkHz / pBaud;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BITS  = 10;

  typedef enum logic [1:0] {IDLE, STATUS, DATA1, DATA2} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [3:0]       r_bit_cnt;
  logic [8:0]       r_shift;
  logic             r_tx;
  logic             r_ready;
  logic             r_tx_stb;
  logic [7:0]       r_tx_byte;
  logic [7:0]       r_last_status;
  logic [6:0]       r_note;
  logic [7:0]       r_data2;

  logic             w_accept;
  logic             w_skip;
  logic             w_start;
  logic             w_bit_end;
  logic             w_frame_end;
  logic [7:0]       w_req_status;
  logic [7:0]       w_req_data2;
  logic [7:0]       w_start_byte;

  assign w_bit_end   = (r_baud_cnt == CNT_W'(DIV - 1));
  assign w_frame_end = w_bit_end && (r_bit_cnt == 4'(BITS - 1));

  // Request decode: note-off wins over note-on when both strobes are high.
  always_comb begin
    w_req_status = {4'h9, if_midi.iMidiCh};
    w_req_data2  = {1'b0, if_midi.iVelocity};
    if (if_midi.iNoteOff) begin
      if (pRunStat != 0) begin
        w_req_data2 = 8'h00;
      end else begin
        w_req_status = {4'h8, if_midi.iMidiCh};
        w_req_data2  = 8'h40;
      end
    end
    w_skip   = (pRunStat != 0) && (w_req_status == r_last_status);
    w_accept = (r_state == IDLE) && (if_midi.iNoteOn || if_midi.iNoteOff);
  end

  // Next state and byte-start control.
  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_start_byte = 8'h00;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_start = 1'b1;
          if (w_skip) begin
            w_state_nxt  = DATA1;
            w_start_byte = {1'b0, if_midi.iNoteNumber};
          end else begin
            w_state_nxt  = STATUS;
            w_start_byte = w_req_status;
          end
        end
      end
      STATUS: begin
        if (w_frame_end) begin
          w_state_nxt  = DATA1;
          w_start      = 1'b1;
          w_start_byte = {1'b0, r_note};
        end
      end
      DATA1: begin
        if (w_frame_end) begin
          w_state_nxt  = DATA2;
          w_start      = 1'b1;
          w_start_byte = r_data2;
        end
      end
      DATA2: begin
        if (w_frame_end) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register, request latch and bit serialiser.
  always_ff @(posedge iCLK or negedge inRST) begin
    if (!inRST) begin
      r_state       <= IDLE;
      r_ready       <= 1'b1;
      r_tx          <= 1'b1;
      r_tx_stb      <= 1'b0;
      r_tx_byte     <= 8'h00;
      r_last_status <= 8'h00;
      r_note        <= 7'h00;
      r_data2       <= 8'h00;
      r_shift       <= 9'h1FF;
      r_baud_cnt    <= '0;
      r_bit_cnt     <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_ready  <= (w_state_nxt == IDLE);
      r_tx_stb <= w_start;
      if (w_accept) begin
        r_note  <= if_midi.iNoteNumber;
        r_data2 <= w_req_data2;
        if (!w_skip) begin
          r_last_status <= w_req_status;
        end
      end
      if (w_start) begin
        r_tx_byte  <= w_start_byte;
        r_tx       <= 1'b0;
        r_shift    <= {1'b1, w_start_byte};
        r_baud_cnt <= '0;
        r_bit_cnt  <= 4'd0;
      end else if (r_state != IDLE) begin
        if (w_bit_end) begin
          r_baud_cnt <= '0;
          if (w_frame_end) begin
            r_tx      <= 1'b1;
            r_bit_cnt <= 4'd0;
          end else begin
            r_tx      <= r_shift[0];
            r_shift   <= {1'b1, r_shift[8:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end else begin
          r_baud_cnt <= r_baud_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign if_midi.oReady     = r_ready;
  assign if_midi.oMidiTx    = r_tx;
  assign if_midi.oTxByte    = r_tx_byte;
  assign if_midi.oTxByteStb = r_tx_stb;

endmodule

// File: tb/tb_midi_note_encoder.sv
// Drives two encoders (running status on/off) and decodes their UART lines
// against a message-level reference model.
module tb_midi_note_encoder;

  localparam int DIV   = 10;
  localparam int FRAME = 10 * DIV;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;

  midi_note_encoder_if bus0();
  midi_note_encoder_if bus1();

  midi_note_encoder #(.pClkHz(312500), .pBaud(31250), .pRunStat(1)) u_dut_rs (
    .iCLK(clk), .inRST(rst_n), .if_midi(bus0)
  );
  midi_note_encoder #(.pClkHz(312500), .pBaud(31250), .pRunStat(0)) u_dut_nrs (
    .iCLK(clk), .inRST(rst_n), .if_midi(bus1)
  );

  logic [1:0] w_tx, w_rdy, w_stb;
  logic [7:0] w_byte [2];
  assign w_tx[0]   = bus0.oMidiTx;
  assign w_tx[1]   = bus1.oMidiTx;
  assign w_rdy[0]  = bus0.oReady;
  assign w_rdy[1]  = bus1.oReady;
  assign w_stb[0]  = bus0.oTxByteStb;
  assign w_stb[1]  = bus1.oTxByteStb;
  assign w_byte[0] = bus0.oTxByte;
  assign w_byte[1] = bus1.oTxByte;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // UART receiver per line: mid-bit sampling, entries are {dut, frame_ok, byte}.
  logic [9:0] rx_q[$];
  logic [8:0] stb_q[$];
  int         stb_t[$];
  bit         rx_busy [2];
  int         rx_cnt  [2];
  logic [7:0] rx_sh   [2];
  bit         rx_ok   [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        rx_busy[d] = 1'b0;
      end else if (!rx_busy[d]) begin
        if (!w_tx[d]) begin
          rx_busy[d] = 1'b1;
          rx_cnt[d]  = 0;
          rx_ok[d]   = 1'b1;
        end
      end else begin
        rx_cnt[d]++;
        if (rx_cnt[d] % DIV == DIV / 2 - 1) begin
          if (rx_cnt[d] / DIV == 0) begin
            if (w_tx[d] !== 1'b0) rx_ok[d] = 1'b0;
          end else if (rx_cnt[d] / DIV <= 8) begin
            rx_sh[d][rx_cnt[d] / DIV - 1] = w_tx[d];
          end else begin
            if (w_tx[d] !== 1'b1) rx_ok[d] = 1'b0;
            rx_q.push_back({d[0], rx_ok[d], rx_sh[d]});
            rx_busy[d] = 1'b0;
          end
        end
      end
      if (rst_n && w_stb[d]) begin
        stb_q.push_back({d[0], w_byte[d]});
        stb_t.push_back(cyc);
      end
    end
  end

  // Reference model: last status byte sent per encoder.
  logic [7:0] mdl_last [2];

  function automatic void model(input int d, input bit on, input bit off,
                                input logic [6:0] note, input logic [6:0] vel,
                                input logic [3:0] ch, output logic [7:0] exp[$]);
    bit         rs;
    logic [7:0] status, d2;
    rs = (d == 0);
    exp = {};
    if (off) begin
      status = rs ? (8'h90 + 8'(ch)) : (8'h80 + 8'(ch));
      d2     = rs ? 8'h00 : 8'h40;
    end else begin
      status = 8'h90 + 8'(ch);
      d2     = 8'(vel);
    end
    if (!(rs && status == mdl_last[d])) begin
      exp.push_back(status);
      mdl_last[d] = status;
    end
    exp.push_back(8'(note));
    exp.push_back(d2);
    if (!on && !off) exp = {};
  endfunction

  task automatic drive(input int d, input bit on, input bit off,
                       input logic [6:0] note, input logic [6:0] vel, input logic [3:0] ch);
    if (d == 0) begin
      bus0.iNoteOn = on; bus0.iNoteOff = off;
      bus0.iNoteNumber = note; bus0.iVelocity = vel; bus0.iMidiCh = ch;
    end else begin
      bus1.iNoteOn = on; bus1.iNoteOff = off;
      bus1.iNoteNumber = note; bus1.iVelocity = vel; bus1.iMidiCh = ch;
    end
  endtask

  task automatic wait_ready(input int d);
    int n;
    n = 0;
    while (!w_rdy[d] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(w_rdy[d]), 32'd1);
  endtask

  // One request; busy_at>0 pulses a second note-on that must be dropped.
  task automatic send(input int d, input bit on, input bit off,
                      input logic [6:0] note, input logic [6:0] vel, input logic [3:0] ch,
                      input int busy_at, input int nlit, input logic [23:0] lit);
    logic [7:0] exp[$];
    logic [23:0] lv;
    int lowc;
    wait_ready(d);
    rx_q = {}; stb_q = {}; stb_t = {};
    model(d, on, off, note, vel, ch, exp);
    drive(d, on, off, note, vel, ch);
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 7'd0, 7'd0, 4'd0);
    lowc = 0;
    while (!w_rdy[d] && lowc < 1000) begin
      lowc++;
      if (busy_at > 0 && lowc == busy_at) drive(d, 1'b1, 1'b0, 7'd99, 7'd99, 4'd7);
      if (busy_at > 0 && lowc == busy_at + 1) drive(d, 1'b0, 1'b0, 7'd0, 7'd0, 4'd0);
      @(negedge clk);
    end
    check("busy_len", 32'(lowc), 32'(FRAME * exp.size()));
    repeat (3) @(negedge clk);
    check("rx_count", 32'(rx_q.size()), 32'(exp.size()));
    check("stb_count", 32'(stb_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
      check("rx_byte", 32'(rx_q[i]), 32'({d[0], 1'b1, exp[i]}));
    for (int i = 0; i < exp.size() && i < stb_q.size(); i++) begin
      check("stb_byte", 32'(stb_q[i]), 32'({d[0], exp[i]}));
      if (i > 0) check("stb_spacing", 32'(stb_t[i] - stb_t[i-1]), 32'(FRAME));
    end
    if (nlit > 0) begin
      check("lit_len", 32'(rx_q.size()), 32'(nlit));
      lv = lit;
      for (int i = 0; i < nlit && i < rx_q.size(); i++)
        check("lit_byte", 32'(rx_q[i][7:0]), 32'(lv[23 - 8*i -: 8]));
    end
  endtask

  initial begin
    bit bad_tx, bad_rdy, bad_stb;
    bit on, off;
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    mdl_last[0] = 8'h00;
    mdl_last[1] = 8'h00;
    drive(0, 1'b0, 1'b0, 7'd0, 7'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 7'd0, 7'd0, 4'd0);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_tx", 32'(w_tx[d]), 32'd1);
      check("rst_ready", 32'(w_rdy[d]), 32'd1);
      check("rst_stb", 32'(w_stb[d]), 32'd0);
      check("rst_byte", 32'(w_byte[d]), 32'h00);
    end
    rst_n = 1'b1;
    bad_tx = 0; bad_rdy = 0; bad_stb = 0;
    repeat (100) begin
      @(negedge clk);
      if (w_tx !== 2'b11) bad_tx = 1;
      if (w_rdy !== 2'b11) bad_rdy = 1;
      if (w_stb !== 2'b00) bad_stb = 1;
    end
    check("idle_tx", 32'(bad_tx), 32'd0);
    check("idle_ready", 32'(bad_rdy), 32'd0);
    check("idle_stb", 32'(bad_stb), 32'd0);

    // Directed message sequence on both encoders.
    for (int d = 0; d < 2; d++) begin
      send(d, 1, 0, 7'd60, 7'd100, 4'd0, 0, 3, 24'h903C64);
      if (d == 0) send(d, 1, 0, 7'd64, 7'd80, 4'd0, 0, 2, 24'h405000);
      else        send(d, 1, 0, 7'd64, 7'd80, 4'd0, 0, 3, 24'h904050);
      send(d, 1, 0, 7'd64, 7'd80, 4'd1, 0, 3, 24'h914050);
      if (d == 0) send(d, 0, 1, 7'd64, 7'd0, 4'd1, 0, 2, 24'h400000);
      else        send(d, 0, 1, 7'd64, 7'd0, 4'd1, 0, 3, 24'h814040);
      if (d == 0) send(d, 1, 1, 7'd64, 7'd33, 4'd1, 50, 2, 24'h400000);
      else        send(d, 1, 1, 7'd64, 7'd33, 4'd1, 50, 3, 24'h814040);
    end

    // Randomized requests against the model.
    for (int k = 0; k < 30; k++) begin
      on  = 1'($urandom_range(0, 1));
      off = 1'($urandom_range(0, 1));
      if (!on && !off) on = 1'b1;
      send(k % 2, on, off, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
           4'($urandom_range(0, 3)), 0, 0, 24'h0);
    end

    // Reset in the middle of DATA1 of a 3-byte message.
    wait_ready(0);
    drive(0, 1'b1, 1'b0, 7'd0, 7'd5, 4'd15);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 7'd0, 7'd0, 4'd0);
    repeat (150) @(negedge clk);
    check("mid_tx_low", 32'(w_tx[0]), 32'd0);
    check("mid_busy", 32'(w_rdy[0]), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_tx", 32'(w_tx[0]), 32'd1);
    check("abort_ready", 32'(w_rdy[0]), 32'd1);
    check("abort_stb", 32'(w_stb[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mdl_last[0] = 8'h00;
    mdl_last[1] = 8'h00;
    repeat (2) @(negedge clk);
    send(0, 1, 0, 7'd60, 7'd100, 4'd0, 0, 3, 24'h903C64);
    send(1, 1, 0, 7'd60, 7'd100, 4'd0, 0, 3, 24'h903C64);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
